// File: rtl/col_driver.sv
// Sequenced bit-line driver for the CAM/MAC column periphery: precharge-then-drive
// per bit phase, one-hot column select (CAM) or LSB-first bit-serial operands (MAC).
module col_driver #(
  parameter  int COLS    = 8,
  parameter  int ADDR_W  = 3,
  parameter  int OP_BITS = 4,
  parameter  int PRE_CYC = 1,
  parameter  int DRV_CYC = 2,
  localparam int BIT_W   = (OP_BITS > 1) ? $clog2(OP_BITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_mac,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [COLS*OP_BITS-1:0] req_data,
  input  logic                    abort,
  output logic [COLS-1:0]         bl,
  output logic [COLS-1:0]         blb,
  output logic                    drive_en,
  output logic [BIT_W-1:0]        bit_idx,
  output logic                    done,
  output logic                    addr_err
);

  localparam int MAX_CYC = (PRE_CYC > DRV_CYC) ? PRE_CYC : DRV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((PRE_CYC > 0) ? PRE_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(DRV_CYC - 1);
  localparam logic [BIT_W-1:0] MAC_LAST = BIT_W'(OP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam state_t PHASE_START = (PRE_CYC > 0) ? S_PRE : S_DRIVE;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    mac_q, mac_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [COLS*OP_BITS-1:0] data_q, data_d;
  logic                    ready_q, ready_d;
  logic [COLS-1:0]         bl_q, bl_d, blb_q, blb_d;
  logic                    drive_en_q, drive_en_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [COLS-1:0]         sel_s;

  // Sequencer: request capture, phase counting, abort and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    mac_d   = mac_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = PHASE_START;
          cnt_d   = '0;
          bit_d   = '0;
          mac_d   = req_mac;
          addr_d  = req_addr;
          data_d  = req_data;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bit_d   = '0;
        end else if (cnt_q == PRE_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bit_d   = '0;
        end else if (cnt_q == DRV_LAST) begin
          cnt_d = '0;
          if (mac_q && (bit_q != MAC_LAST)) begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = PHASE_START;
          end else begin
            state_d = S_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
            err_d   = !mac_q && ({1'b0, addr_q} >= (ADDR_W + 1)'(COLS));
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line values are derived from the next state so every output leaves a flop.
  always_comb begin
    sel_s      = '0;
    bl_d       = '0;
    blb_d      = '0;
    ready_d    = (state_d == S_IDLE);
    drive_en_d = (state_d == S_DRIVE);
    for (int c = 0; c < COLS; c++) begin
      if (mac_d) begin
        sel_s[c] = data_d[c*OP_BITS + int'(bit_d)];
      end else begin
        sel_s[c] = (addr_d == ADDR_W'(c));
      end
    end
    case (state_d)
      S_PRE: begin
        bl_d  = '1;
        blb_d = '1;
      end
      S_DRIVE: begin
        bl_d  = sel_s;
        blb_d = ~sel_s;
      end
      default: begin
        bl_d  = '0;
        blb_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      mac_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ready_q    <= 1'b1;
      bl_q       <= '0;
      blb_q      <= '0;
      drive_en_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      mac_q      <= mac_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      bl_q       <= bl_d;
      blb_q      <= blb_d;
      drive_en_q <= drive_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign bl        = bl_q;
  assign blb       = blb_q;
  assign drive_en  = drive_en_q;
  assign bit_idx   = bit_q;
  assign done      = done_q;
  assign addr_err  = err_q;

endmodule

// File: doc/col_driver.md
# col_driver

Parametrised, sequenced bit-line driver for the CAM/MAC column periphery. It generalises the fixed 8-column combinational column decoder to COLS columns. Each request runs through a precharge-then-drive sequence with a valid/ready handshake. MAC mode streams multi-bit operands bit-serially onto the bit lines, LSB first. It sits between the array controller and the bit-line driver cells of the CAM/MAC array.

## Interface
- COLS, 8: number of columns driven; 2 ≤ COLS ≤ 2**ADDR_W
- ADDR_W, 3: column address width
- OP_BITS, 4: MAC operand width per column (bits streamed serially); ≥ 1
- PRE_CYC, 1: precharge cycles per bit phase; 0 skips precharge
- DRV_CYC, 2: drive cycles per bit phase; ≥ 1
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_mac  in  1  1 = MAC operand stream, 0 = CAM one-hot column select
- req_addr  in  ADDR_W  CAM column address (ignored in MAC)
- req_data  in  COLS*OP_BITS  MAC operands; column c bit b = req_data[c*OP_BITS+b] (ignored in CAM)
- abort  in  1  synchronous cancel of the running sequence
- bl  out  COLS  bit lines
- blb  out  COLS  complement bit lines
- drive_en  out  1  high during drive cycles
- bit_idx  out  max(1,$clog2(OP_BITS))  operand bit currently on the lines (0 in CAM)
- done  out  1  one-cycle completion pulse
- addr_err  out  1  valid with done; CAM address ≥ COLS

## Operation
- Handshake: accept when req_valid && req_ready. All request fields are registered on acceptance and held for the whole sequence. Inputs are not sampled again until the next IDLE.
- States and transitions:
  - IDLE → PRE on accept when PRE_CYC > 0; IDLE → DRIVE on accept when PRE_CYC = 0.
  - PRE lasts PRE_CYC cycles, then → DRIVE.
  - DRIVE lasts DRV_CYC cycles. Then → PRE/DRIVE for the next bit while bit_idx < last bit; otherwise → IDLE with done = 1.
- Bit phases: CAM has 1 phase, MAC has OP_BITS phases. bit_idx increments by 1 at each phase boundary and returns to 0 in IDLE.
- Outputs are all registered; there is no combinational path from inputs to bl/blb.
  - IDLE: bl = 0, blb = 0, drive_en = 0 (drivers released).
  - PRE: bl = all 1, blb = all 1, drive_en = 0.
  - DRIVE, CAM: bl = one-hot(addr), blb = ~bl. If addr ≥ COLS: bl = 0, blb = all 1, addr_err = 1 with done.
  - DRIVE, MAC: bl[c] = operand c bit bit_idx, blb = ~bl.
- abort: in any non-IDLE state, the next cycle is IDLE with outputs idle and no done. abort is ignored in IDLE. abort takes priority over the normal transition in the same cycle.
- done and accept can coincide: done is high in the first IDLE cycle, and req_ready is high in that same cycle, so back-to-back requests have no bubble beyond that IDLE cycle.

## Timing
- Reset values: bl = 0, blb = 0, drive_en = 0, bit_idx = 0, done = 0, addr_err = 0, req_ready = 1, state IDLE.
- Async reset mid-sequence: outputs go to their reset values immediately, with no done pulse.
- Cycle numbering: accept edge = cycle 0. Cycles 1..PRE_CYC are PRE, the next DRV_CYC cycles are DRIVE, and so on.
- Phase length P = PRE_CYC + DRV_CYC. Bit b drives cycles PRE_CYC+1+b·P through (b+1)·P.
- done asserts in cycle N·P + 1, where N = 1 (CAM) or OP_BITS (MAC).
- Back-to-back throughput: one request every N·P + 1 cycles.
- bl and blb are never both driven to complementary values outside DRIVE. bl = blb = 1 occurs only in PRE.

## Test plan
Parameters for all tests: COLS = 8, OP_BITS = 4, PRE_CYC = 1, DRV_CYC = 2.
- **CAM address 5:** cycle 1 shows bl = blb = 8'hFF. Cycles 2–3 show bl = 8'h20, blb = 8'hDF, drive_en = 1. Cycle 4 shows done = 1, addr_err = 0, bl = blb = 0.
- **MAC, column c operand = c[3:0]** (req_data = 32'h76543210): bit 0 drive cycles 2–3 show bl = 8'hAA. Bit 1 cycles 5–6 show 8'hCC. Bit 2 cycles 8–9 show 8'hF0. Bit 3 cycles 11–12 show 8'h00. done in cycle 13. Each bit phase is preceded by a PRE cycle at 8'hFF.
- **Back-to-back:** req_valid held high with two CAM requests (addr 0, then 7). The second is accepted in the done cycle (cycle 4). Its drive shows bl = 8'h80 in cycles 6–7.
- **abort:** abort during MAC bit 1 drive (cycle 5). Cycle 6 is IDLE, bl = blb = 0, no done. req_ready = 1 in cycle 6.
- **Async rst:** rst asserted mid-drive without a clock edge. bl, blb and drive_en go to 0 immediately. After release, a CAM request completes normally.
- **COLS = 6, addr = 7:** bl = 0, blb = 6'h3F during drive. done and addr_err both pulse in cycle 4.
